// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and entry type for the write-back stage buffer.
package wb_pkg;
  localparam int XLEN_MAX = 64;
  localparam int RD_W = 5;
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;
  localparam logic [1:0] LD_DWORD = 2'b11;
  typedef struct packed {
    logic [XLEN_MAX-1:0] data;
    logic [RD_W-1:0]     rd;
    logic                we;
    logic                misalign;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: shifts, truncates and extends raw load data; flags misaligned loads.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic            unsigned_ld,
  input  logic [2:0]      byte_off,
  output logic [XLEN-1:0] data,
  output logic            misalign
);
  logic [2:0]  off;
  logic [1:0]  sz;
  logic [63:0] sh;
  logic [63:0] ext;
  // A 32-bit datapath has no doubleword and only a 2-bit offset.
  always_comb begin
    off = (XLEN == 32) ? {1'b0, byte_off[1:0]} : byte_off;
    sz = (XLEN == 32 && size == LD_DWORD) ? LD_WORD : size;
    sh = 64'(rdata) >> {off, 3'b000};
    ext = (sz == LD_BYTE) ? {{56{!unsigned_ld & sh[7]}}, sh[7:0]} :
          (sz == LD_HALF) ? {{48{!unsigned_ld & sh[15]}}, sh[15:0]} :
          (sz == LD_WORD) ? {{32{!unsigned_ld & sh[31]}}, sh[31:0]} : sh;
    misalign = (sz == LD_HALF) ? off[0] :
               (sz == LD_WORD) ? |off[1:0] :
               (sz == LD_DWORD) ? |off : 1'b0;
    data = ext[XLEN-1:0];
  end
endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: write-back stage with result select, load formatting and a 2-entry skid buffer.
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int WB_SEL_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [XLEN-1:0]       m_result,
  input  logic [XLEN-1:0]       m_rdata,
  input  logic [XLEN-1:0]       m_pc_plus4,
  input  logic [WB_SEL_W-1:0]   m_wb_sel,
  input  logic [1:0]            m_ld_size,
  input  logic                  m_ld_unsigned,
  input  logic [2:0]            m_byte_off,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  m_reg_write,
  input  logic                  rf_ready,
  output logic                  wb_valid,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_misalign,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
);
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic            is_mem, is_pc4, accept, drain;
  logic            head_v, skid_v, head_v_n, skid_v_n;
  wb_entry_t       in_e, head, skid, head_n, skid_n;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata       (m_rdata),
    .size        (m_ld_size),
    .unsigned_ld (m_ld_unsigned),
    .byte_off    (m_byte_off),
    .data        (ld_data),
    .misalign    (ld_mis)
  );

  always_comb begin
    is_mem = m_wb_sel == WB_SEL_W'(WB_SEL_MEM);
    is_pc4 = m_wb_sel == WB_SEL_W'(WB_SEL_PC4);
    in_e.data = XLEN_MAX'(is_mem ? ld_data : is_pc4 ? m_pc_plus4 : m_result);
    in_e.rd = RD_W'(m_rd);
    in_e.misalign = is_mem & ld_mis;
    in_e.we = m_reg_write & (|m_rd) & !(is_mem & ld_mis);
  end

  assign accept = m_valid & m_ready;
  assign drain  = head_v & rf_ready;

  // Skid always refills head first so FIFO order holds across stalls.
  always_comb begin
    head_n = head;
    skid_n = skid;
    head_v_n = head_v;
    skid_v_n = skid_v;
    if (!head_v || drain) begin
      head_v_n = skid_v | accept;
      head_n = skid_v ? skid : accept ? in_e : head;
      skid_v_n = skid_v & accept;
      skid_n = (skid_v & accept) ? in_e : skid;
    end else if (accept) begin
      skid_v_n = 1'b1;
      skid_n = in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      m_ready <= 1'b1;
      head <= '0;
      skid <= '0;
    end else begin
      head_v <= head_v_n;
      skid_v <= skid_v_n;
      m_ready <= !skid_v_n;
      head <= head_n;
      skid <= skid_n;
    end
  end

  assign wb_valid    = head_v;
  assign reg_write   = head_v & rf_ready & head.we;
  assign wb_rd       = REG_ADDR_W'(head.rd);
  assign wb_data     = head.data[XLEN-1:0];
  assign wb_misalign = head_v & head.misalign;
  assign fwd_valid   = head_v & head.we;
  assign fwd_rd      = wb_rd;
  assign fwd_data    = wb_data;
endmodule

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
- Parametrised successor to the single-register write-back stage of the RISC-V datapath, between the MEM stage and the register file.
- Selects the result source: ALU, formatted load data, or PC+4.
- Aligns and extends sub-word loads, and suppresses writes to x0 and misaligned loads.
- Decouples MEM from the register-file port with a valid/ready handshake and a 2-entry skid buffer. Also exports a forwarding view of the head entry.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64
REG_ADDR_W, 5, register index width
WB_SEL_W, 2, width of result-source select

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush; discards all buffered entries
m_valid  in  1  MEM stage presents an entry
m_ready  out  1  stage can accept an entry; registered
m_result  in  XLEN  ALU result
m_rdata  in  XLEN  raw memory read word
m_pc_plus4  in  XLEN  link value for JAL/JALR
m_wb_sel  in  WB_SEL_W  00 ALU, 01 MEM, 10 PC+4, 11 treated as ALU
m_ld_size  in  2  00 byte, 01 half, 10 word, 11 dword
m_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
m_byte_off  in  3  byte offset of the load address within the XLEN word
m_rd  in  REG_ADDR_W  destination register
m_reg_write  in  1  instruction writes rd
rf_ready  in  1  register-file write port available this cycle
wb_valid  out  1  head entry valid
reg_write  out  1  write strobe = wb_valid & rf_ready & head write-enable
wb_rd  out  REG_ADDR_W  head destination
wb_data  out  XLEN  head write data
wb_misalign  out  1  head entry was a misaligned load; valid with wb_valid
fwd_valid  out  1  head entry valid, write-enabled, rd != 0
fwd_rd  out  REG_ADDR_W  equals wb_rd
fwd_data  out  XLEN  equals wb_data

Behaviour:
- Reset:
  - Every output is 0 except m_ready, which is 1.
  - Head and skid entries are invalid.
- Flush: same effect as reset on valid bits and m_ready. An entry offered in the flush cycle is dropped.
- Formatting (combinational, before storage):
  - Load data is m_rdata >> (8*m_byte_off), truncated to size, then extended per m_ld_unsigned.
  - Misaligned when m_byte_off is not a multiple of the size in bytes.
  - XLEN=32: m_byte_off[2] is ignored, and size 11 is treated as word.
- Stored write-enable = m_reg_write & (m_rd != 0) & !misaligned. Misalignment counts only when m_wb_sel = 01.
- Accept when m_valid & m_ready. Drain when wb_valid & rf_ready.
- Head slot:
  - Loaded from input when head is empty or draining and skid is empty.
  - Loaded from skid when draining and skid is full.
- Skid slot: loaded when accepting while head is full and not draining.
- Simultaneous accept and drain with skid full: skid moves to head; the input goes to skid.
- m_ready next = !(skid valid after this edge).
- Latency: accepted entry appears on wb_* the next cycle when the buffer is empty.
- Throughput: 1 entry/cycle while rf_ready = 1.
- Ordering: strictly FIFO. No entry is ever duplicated or dropped except by flush/reset.
- Outputs are held stable while wb_valid & !rf_ready.
- reg_write never asserts for rd=0 or a misaligned load. That entry still drains.

Decomposition:
- Shared package wb_pkg holds:
  - WB_SEL_ALU/MEM/PC4 constants
  - LD_BYTE/HALF/WORD/DWORD constants
  - wb_entry_t struct {data, rd, we, misalign}
- Sub-module wb_load_align: combinational shift, extend and misalign detect; parametrised by XLEN.

Test Plan:
- Reset then idle → m_ready=1, wb_valid=0, reg_write=0.
- MEM lb, rdata=0x00000000_0000_80FF, off=1, signed, rd=5, rf_ready=1 → next cycle wb_data=0xFFFF_FFFF_FFFF_FF80, reg_write=1, wb_rd=5.
- lhu off=3 → wb_misalign=1, reg_write=0, entry drains; lwu off=4, rdata=0xDEADBEEF_00000000 → wb_data=0x00000000_DEADBEEF.
- rf_ready=0 for 3 cycles with 3 back-to-back ALU entries (0x11, 0x22, 0x33) → m_ready drops after the 2nd accept; then rf_ready=1 → writes 0x11, 0x22, 0x33 in order, no loss.
- ALU write to rd=0 → wb_valid=1, reg_write=0, fwd_valid=0; JAL with wb_sel=10, pc_plus4=0x1004 → wb_data=0x1004.
- Buffer full, flush=1 with m_valid=1 → next cycle wb_valid=0, m_ready=1, nothing written.
